// File: rtl/cpu_exec_ctrl_if.sv
// cpu_exec_ctrl_if: board buttons and CPU halt into the execution controller,
// CPU clock-enable/reset and status out of it.
interface cpu_exec_ctrl_if;
    logic        btn_run;
    logic        btn_step;
    logic        btn_clr;
    logic        halt;
    logic        cpu_en;
    logic        cpu_reset;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    modport master (
        output btn_run, btn_step, btn_clr, halt,
        input  cpu_en, cpu_reset, state, cycle_count
    );

    modport slave (
        input  btn_run, btn_step, btn_clr, halt,
        output cpu_en, cpu_reset, state, cycle_count
    );
endinterface

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: debounces run/step/clear buttons and sequences the CPU through
// a registered clock-enable and synchronous reset, stopping on CPU halt.
module cpu_exec_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 1,
    parameter int RST_CYCLES      = 4
) (
    input logic            clk,
    input logic            reset_n,
    cpu_exec_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int VW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
    localparam int RW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {S_RESET, S_PAUSE, S_RUN, S_HALT} state_t;

    logic [2:0]          btn, sync1_q, sync2_q, db_q, db_d, db_prev_q, press;
    logic [2:0][DW-1:0]  cnt_q, cnt_d;
    state_t              state_q;
    logic                cpu_en_q, cpu_reset_q, fire_run;
    logic [31:0]         count_q, count_inc;
    logic [VW-1:0]       div_q, div_nx;
    logic [RW-1:0]       rst_q;

    // bit 0 = run, bit 1 = step, bit 2 = clear
    assign btn   = {bus.btn_clr, bus.btn_step, bus.btn_run};
    assign press = db_q & ~db_prev_q;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int b = 0; b < 3; b++) begin
            db_d[b]  = (sync2_q[b] != db_q[b] && cnt_q[b] == DW'(DEBOUNCE_CYCLES - 1)) ? sync2_q[b] : db_q[b];
            cnt_d[b] = (sync2_q[b] != db_q[b] && cnt_q[b] != DW'(DEBOUNCE_CYCLES - 1)) ? cnt_q[b] + DW'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    // div_q is held at 0 outside RUN, so the entry cycle counts as k=1
    assign div_nx    = (div_q == VW'(RUN_DIV - 1)) ? '0 : div_q + VW'(1);
    assign fire_run  = (div_nx == '0);
    assign count_inc = (&count_q) ? count_q : count_q + 32'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RESET;
            cpu_reset_q <= 1'b1;
            cpu_en_q    <= 1'b0;
            count_q     <= '0;
            div_q       <= '0;
            rst_q       <= '0;
        end else begin
            cpu_en_q <= 1'b0;
            div_q    <= '0;
            if (state_q != S_RESET && press[2]) begin
                state_q     <= S_RESET;
                cpu_reset_q <= 1'b1;
                count_q     <= '0;
            end else begin
                case (state_q)
                    S_RESET: begin
                        rst_q <= (rst_q == RW'(RST_CYCLES - 1)) ? '0 : rst_q + RW'(1);
                        if (rst_q == RW'(RST_CYCLES - 1)) begin
                            state_q     <= S_PAUSE;
                            cpu_reset_q <= 1'b0;
                        end
                    end
                    S_PAUSE, S_RUN: begin
                        if (bus.halt) begin
                            state_q <= S_HALT;
                        end else if (press[0] && state_q == S_RUN) begin
                            state_q <= S_PAUSE;
                        end else if (press[0] || state_q == S_RUN) begin
                            state_q  <= S_RUN;
                            div_q    <= div_nx;
                            cpu_en_q <= fire_run;
                            count_q  <= fire_run ? count_inc : count_q;
                        end else if (press[1]) begin
                            cpu_en_q <= 1'b1;
                            count_q  <= count_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.state       = state_q;
    assign bus.cpu_en      = cpu_en_q;
    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.cycle_count = count_q;
endmodule
